// File: rtl/pickup_code_entry_pkg.sv
// Shared types and constants for the pickup code entry block.
// Digits arrive as 4-bit nibbles from the keypad decoder; only 0..7 are real keys.
package pickup_code_entry_pkg;

    localparam int          DIGIT_W   = 4;
    localparam logic [3:0]  DIGIT_MAX = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_LOCK
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pickup_code_entry_cycle_timer.sv
// Free-running cycle counter shared by the timeout, open and lock intervals.
// Stops at the programmed limit so it never wraps while the FSM sits idle.
module cycle_timer #(
    parameter int W = 15
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic [W-1:0] i_limit,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    assign o_done = (r_cnt == i_limit);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (!o_done) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pickup_code_entry.sv
// Collects keypad digits, compares them with the stored compartment code and
// drives unlock, error and lockout status with inter-digit timeout.
module pickup_code_entry
    import pickup_code_entry_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int TIMEOUT_CYC = 5000,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYC    = 10000,
    parameter int OPEN_CYC    = 2000
) (
    input  logic                      i_clk_1k,
    input  logic                      i_rst,
    input  logic [DIGIT_W-1:0]        i_num_in,
    input  logic                      i_plus,
    input  logic [DIGIT_W*DIGITS-1:0] i_code_ref,
    output logic [DIGIT_W*DIGITS-1:0] o_entry,
    output logic [2:0]                o_count,
    output logic                      o_unlock,
    output logic                      o_err,
    output logic                      o_locked,
    output logic [1:0]                o_fail_cnt
);

    localparam int         TMR_W    = $clog2(max3(TIMEOUT_CYC, LOCK_CYC, OPEN_CYC)) + 1;
    localparam logic [2:0] LAST_CNT = 3'(DIGITS);
    localparam logic [1:0] FAIL_LIM = 2'(MAX_FAIL);

    state_t                    r_state;
    state_t                    w_next;
    logic                      r_plus_d;
    logic [DIGIT_W*DIGITS-1:0] r_entry;
    logic [2:0]                r_count;
    logic                      r_err;
    logic [1:0]                r_fail_cnt;

    logic                      w_key;
    logic                      w_valid;
    logic                      w_store;
    logic                      w_clear_entry;
    logic                      w_err_set;
    logic                      w_fail_inc;
    logic                      w_fail_clr;
    logic                      w_timer_kick;
    logic                      w_timer_clear;
    logic                      w_timer_done;
    logic [TMR_W-1:0]          w_limit;
    logic [1:0]                w_fail_next;

    // Only a fresh press of a real digit key counts; invalid codes are dropped.
    assign w_key       = i_plus & ~r_plus_d;
    assign w_valid     = w_key & (i_num_in <= DIGIT_MAX);
    assign w_fail_next = (r_fail_cnt == FAIL_LIM) ? r_fail_cnt : r_fail_cnt + 2'd1;

    always_ff @(posedge i_clk_1k) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_store       = 1'b0;
        w_clear_entry = 1'b0;
        w_err_set     = 1'b0;
        w_fail_inc    = 1'b0;
        w_fail_clr    = 1'b0;
        w_timer_kick  = 1'b0;
        w_limit       = TMR_W'(TIMEOUT_CYC - 1);
        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    w_store = 1'b1;
                    w_next  = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (r_count == LAST_CNT) begin
                    w_next = S_CHECK;
                end else if (w_valid) begin
                    w_store      = 1'b1;
                    w_timer_kick = 1'b1;
                end else if (w_timer_done) begin
                    w_err_set     = 1'b1;
                    w_clear_entry = 1'b1;
                    w_next        = S_IDLE;
                end
            end
            S_CHECK: begin
                w_clear_entry = 1'b1;
                if (r_entry == i_code_ref) begin
                    w_fail_clr = 1'b1;
                    w_next     = S_OPEN;
                end else begin
                    w_err_set  = 1'b1;
                    w_fail_inc = 1'b1;
                    w_next     = (w_fail_next == FAIL_LIM) ? S_LOCK : S_IDLE;
                end
            end
            S_OPEN: begin
                w_limit = TMR_W'(OPEN_CYC - 1);
                if (w_timer_done) begin
                    w_next = S_IDLE;
                end
            end
            S_LOCK: begin
                w_limit = TMR_W'(LOCK_CYC - 1);
                if (w_timer_done) begin
                    w_fail_clr = 1'b1;
                    w_next     = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_timer_clear = w_timer_kick | (w_next != r_state);

    cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .i_clk   (i_clk_1k),
        .i_rst   (i_rst),
        .i_clear (w_timer_clear),
        .i_limit (w_limit),
        .o_done  (w_timer_done)
    );

    // Digit storage, error pulse and failure counter follow the FSM's decisions.
    always_ff @(posedge i_clk_1k) begin
        if (i_rst) begin
            r_plus_d   <= 1'b0;
            r_entry    <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_fail_cnt <= '0;
        end else begin
            r_plus_d <= i_plus;
            r_err    <= w_err_set;
            if (w_clear_entry) begin
                r_entry <= '0;
                r_count <= '0;
            end else if (w_store) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (r_count == 3'(i)) begin
                        r_entry[i*DIGIT_W +: DIGIT_W] <= i_num_in;
                    end
                end
                r_count <= r_count + 3'd1;
            end
            if (w_fail_clr) begin
                r_fail_cnt <= '0;
            end else if (w_fail_inc) begin
                r_fail_cnt <= w_fail_next;
            end
        end
    end

    assign o_entry    = r_entry;
    assign o_count    = r_count;
    assign o_err      = r_err;
    assign o_fail_cnt = r_fail_cnt;
    assign o_unlock   = (r_state == S_OPEN);
    assign o_locked   = (r_state == S_LOCK);

endmodule
